// File: rtl/pipe_hazard_ctrl_pkg.sv
// Purpose : shared constants for the pipeline hazard controller (state encoding,
//           NOP encoding, zero-register index, timer width and load helper).
// Ports   : none (package).
package pipe_ctrl_pkg;

   // FSM state encoding (2-bit state register)
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MDU_WAIT = 2'd1;

   typedef enum logic [1:0] {
      RUN      = ST_RUN,
      MDU_WAIT = ST_MDU_WAIT
   } state_e;

   // Canonical NOP (sll $0,$0,0) that a flushed IF/ID register holds
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Register $0 never carries a real dependency
   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int TIMER_W = 8;

   // The start cycle is spent in RUN and the final MDU_WAIT cycle has timer==0,
   // so the timer is loaded with two less than the total EX occupancy.
   function automatic logic [TIMER_W-1:0] mdu_timer_init(input int latency);
      return TIMER_W'(latency - 2);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose : bundle between the 5-stage pipeline datapath and the hazard controller.
// Ports   : hazard inputs (ID/EX register fields, branch/MDU status) from the datapath;
//           register enables, flush/bubble controls, MduBusy, StallCount, ErrFlag back.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       IF_ID_RsAddr;
   logic [4:0]       IF_ID_RtAddr;
   logic             IF_ID_UsesRt;
   logic [4:0]       ID_EX_RtAddr;
   logic             ID_EX_MemRead;
   logic             EX_BranchTaken;
   logic             EX_MduStart;

   logic             PCWrite;
   logic             IF_ID_Write;
   logic             IF_ID_Flush;
   logic             ID_EX_Write;
   logic             ID_EX_Bubble;
   logic             EX_MEM_Bubble;
   logic             MduBusy;
   logic [CNT_W-1:0] StallCount;
   logic             ErrFlag;

   // Datapath side: supplies the pipeline status, obeys the controls
   modport master (
      output IF_ID_RsAddr, IF_ID_RtAddr, IF_ID_UsesRt, ID_EX_RtAddr, ID_EX_MemRead,
             EX_BranchTaken, EX_MduStart,
      input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble,
             MduBusy, StallCount, ErrFlag
   );

   // Controller side
   modport slave (
      input  IF_ID_RsAddr, IF_ID_RtAddr, IF_ID_UsesRt, ID_EX_RtAddr, ID_EX_MemRead,
             EX_BranchTaken, EX_MduStart,
      output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble,
             MduBusy, StallCount, ErrFlag
   );

endinterface

// File: rtl/pipe_hazard_ctrl_stall_timer.sv
// Purpose : 8-bit down-counter timing the MDU freeze; load wins over decrement,
//           decrement stops at zero.
// Ports   : clk, rst (sync, active-high), load/load_val, dec -> zero (count == 0).
module stall_timer
   import pipe_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               dec,
   output logic               zero
);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : hazard/sequencing controller for the 5-stage pipeline: load-use stall
//           (1 cycle), taken-branch squash (2 instructions), MDU front-end freeze.
// Ports   : clk, rst (sync, active-high); bus (slave modport) carrying the hazard
//           inputs and PC/IF-ID/ID-EX/EX-MEM controls, MduBusy, StallCount, ErrFlag.
// Controls are combinational from state and inputs; StallCount/ErrFlag are registered.
// MDU_LATENCY legal range is 2..255 (8-bit timer).
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_LATENCY = 4,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave bus
);

   state_e           state_q;
   state_e           state_d;
   logic             err_q;
   logic             err_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   logic load_use;
   logic timer_load;
   logic timer_zero;

   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_write;
   logic id_ex_bubble;
   logic ex_mem_bubble;

   // Load in EX writing a register the ID instruction reads; $0 is never a hazard
   always_comb begin
      load_use = bus.ID_EX_MemRead && (bus.ID_EX_RtAddr != REG_ZERO) &&
                 ((bus.ID_EX_RtAddr == bus.IF_ID_RsAddr) ||
                  (bus.IF_ID_UsesRt && (bus.ID_EX_RtAddr == bus.IF_ID_RtAddr)));
   end

   always_comb begin
      state_d       = state_q;
      err_d         = err_q;
      timer_load    = 1'b0;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;

      if (rst) begin
         // Hold the front end and fill the back end with NOPs until released
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_bubble  = 1'b1;
         ex_mem_bubble = 1'b1;
         state_d       = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (bus.EX_BranchTaken) begin
                  // Squash the two younger instructions; PC keeps loading the target.
                  // An MDU start alongside a taken branch is contradictory: flag it, drop it.
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  if (bus.EX_MduStart) begin
                     err_d = 1'b1;
                  end
               end else if (bus.EX_MduStart) begin
                  // The start cycle itself still advances normally
                  state_d    = MDU_WAIT;
                  timer_load = 1'b1;
               end else if (load_use) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
               end
            end
            MDU_WAIT: begin
               // Freeze everything up to EX; EX/MEM receives bubbles while the op runs
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               id_ex_write   = 1'b0;
               ex_mem_bubble = 1'b1;
               if (timer_zero) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   stall_timer u_stall_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (mdu_timer_init(MDU_LATENCY)),
      .dec      (state_q == MDU_WAIT),
      .zero     (timer_zero)
   );

   assign bus.PCWrite       = pc_write;
   assign bus.IF_ID_Write   = if_id_write;
   assign bus.IF_ID_Flush   = if_id_flush;
   assign bus.ID_EX_Write   = id_ex_write;
   assign bus.ID_EX_Bubble  = id_ex_bubble;
   assign bus.EX_MEM_Bubble = ex_mem_bubble;
   assign bus.MduBusy       = (state_q == MDU_WAIT);
   assign bus.StallCount    = stall_cnt_q;
   assign bus.ErrFlag       = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl; directed hazard scenarios then
//           randomized traffic against a cycle-level behavioural model.
// Ports   : none (top-level bench).
module tb_pipe_hazard_ctrl;

   localparam int LAT = 4;
   localparam int CW  = 6;   // small counter so saturation is reached in the random run

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(
      .MDU_LATENCY (LAT),
      .CNT_W       (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: frozen cycles still owed to an MDU op, stall statistic, sticky error
   int m_frz   = 0;
   int m_stall = 0;
   bit m_err   = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge
   task automatic cycle(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                        input bit uses_rt, input logic [4:0] ex_rt, input bit mr,
                        input bit br, input bit mdu);
      bit e_pc, e_ifw, e_ifl, e_idw, e_idb, e_exb, hz;
      rst                = r;
      bus.IF_ID_RsAddr   = rs;
      bus.IF_ID_RtAddr   = rt;
      bus.IF_ID_UsesRt   = uses_rt;
      bus.ID_EX_RtAddr   = ex_rt;
      bus.ID_EX_MemRead  = mr;
      bus.EX_BranchTaken = br;
      bus.EX_MduStart    = mdu;

      hz = mr && (ex_rt != 5'd0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
      {e_pc, e_ifw, e_ifl, e_idw, e_idb, e_exb} = 6'b110100;
      if (r)               {e_pc, e_ifw, e_ifl, e_idw, e_idb, e_exb} = 6'b001111;
      else if (m_frz > 0)  {e_pc, e_ifw, e_ifl, e_idw, e_idb, e_exb} = 6'b000001;
      else if (br)         {e_pc, e_ifw, e_ifl, e_idw, e_idb, e_exb} = 6'b111110;
      else if (mdu)        {e_pc, e_ifw, e_ifl, e_idw, e_idb, e_exb} = 6'b110100;
      else if (hz)         {e_pc, e_ifw, e_ifl, e_idw, e_idb, e_exb} = 6'b000110;

      @(negedge clk);
      chk("PCWrite",       bus.PCWrite,       e_pc);
      chk("IF_ID_Write",   bus.IF_ID_Write,   e_ifw);
      chk("IF_ID_Flush",   bus.IF_ID_Flush,   e_ifl);
      chk("ID_EX_Write",   bus.ID_EX_Write,   e_idw);
      chk("ID_EX_Bubble",  bus.ID_EX_Bubble,  e_idb);
      chk("EX_MEM_Bubble", bus.EX_MEM_Bubble, e_exb);
      if (!r) chk("MduBusy", bus.MduBusy, (m_frz > 0));
      chk("StallCount",    bus.StallCount,    m_stall);
      chk("ErrFlag",       bus.ErrFlag,       m_err);

      @(posedge clk);
      if (r) begin
         m_frz   = 0;
         m_stall = 0;
         m_err   = 1'b0;
      end else begin
         if (!e_pc && (m_stall < (1 << CW) - 1)) m_stall++;
         if (m_frz > 0)  m_frz--;
         else if (br)    m_err = m_err | mdu;
         else if (mdu)   m_frz = LAT - 1;
      end
      #1;
   endtask

   task automatic idle();
      cycle(0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // 1. Reset held two cycles
      cycle(1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle(1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("rst_stall", bus.StallCount, 0);
      chk("rst_err",   bus.ErrFlag,    0);
      chk("rst_busy",  bus.MduBusy,    0);

      // 2. Load-use via rs; then the same with $0 as destination
      cycle(0, 5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      chk("lu_stall_cnt", bus.StallCount, 1);
      idle();
      cycle(0, 5'd0, 5'd1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);

      // 3. Rt path: only a hazard when rt is a source
      cycle(0, 5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      cycle(0, 5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      chk("rt_stall_cnt", bus.StallCount, 2);

      // 4. Taken branch with a concurrent load-use hazard: squash, no stall
      cycle(0, 5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
      chk("br_stall_cnt", bus.StallCount, 2);

      // 5. MDU op: three frozen cycles, then back to RUN
      cycle(0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < LAT - 1; i++) begin
         cycle(0, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1);  // ignored while frozen
      end
      chk("mdu_stall_cnt", bus.StallCount, 5);
      chk("mdu_done_busy", bus.MduBusy, 0);
      idle();

      // 6. Reset aborts a running MDU op; branch+MDU sets a sticky error
      cycle(0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
      idle();
      cycle(1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("abort_busy", bus.MduBusy, 0);
      idle();
      cycle(0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
      chk("err_set", bus.ErrFlag, 1);
      chk("err_no_mdu", bus.MduBusy, 0);
      idle();
      idle();
      chk("err_sticky", bus.ErrFlag, 1);

      // Randomized traffic; small register range makes collisions frequent
      for (int n = 0; n < 4000; n++) begin
         cycle(($urandom_range(0, 299) == 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
